// File: rtl/bitmap_fetch_arbiter.sv
// Arbitrates one single-port board RAM between display row prefetch (strict priority) and game reads/writes.
// Issue is combinational from IDLE; reads return one cycle later. game_req is held until game_gnt is high.
module bitmap_fetch_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              pix_clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_row,
  input  logic              disp_swap,
  output logic [DATA_W-1:0] bitmap_data,
  input  logic              game_req,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_gnt,
  output logic              game_rvalid,
  output logic [DATA_W-1:0] game_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              clr_flags,
  output logic              disp_overrun,
  output logic              disp_underrun
);

  typedef enum logic [1:0] {IDLE, DISP_WAIT, GAME_WAIT} state_t;

  state_t            state;
  logic              disp_pend;
  logic [ADDR_W-1:0] pend_row;
  logic [DATA_W-1:0] shadow;
  logic              shadow_vld;
  logic              disp_issue;
  logic              game_issue;
  logic              capture;

  always_comb begin
    disp_issue = !rst && (state == IDLE) && disp_pend;
    game_issue = !rst && (state == IDLE) && !disp_pend && game_req;
    capture    = (state == DISP_WAIT);
  end

  assign game_gnt  = game_issue;
  assign mem_en    = disp_issue | game_issue;
  assign mem_we    = game_issue & game_we;
  assign mem_addr  = disp_issue ? pend_row : game_addr;
  assign mem_wdata = game_wdata;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      state         <= IDLE;
      disp_pend     <= 1'b0;
      pend_row      <= '0;
      shadow        <= '0;
      shadow_vld    <= 1'b0;
      bitmap_data   <= '0;
      game_rvalid   <= 1'b0;
      game_rdata    <= '0;
      disp_overrun  <= 1'b0;
      disp_underrun <= 1'b0;
    end else begin
      game_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (disp_issue)
            state <= DISP_WAIT;
          else if (game_issue && !game_we)
            state <= GAME_WAIT;
        end
        DISP_WAIT: state <= IDLE;
        GAME_WAIT: begin
          state       <= IDLE;
          game_rvalid <= 1'b1;
          game_rdata  <= mem_rdata;
        end
        default: state <= IDLE;
      endcase

      // A newer request always replaces the pending row; the issue slot takes the old one.
      if (disp_req) begin
        pend_row  <= disp_row;
        disp_pend <= 1'b1;
      end else if (disp_issue) begin
        disp_pend <= 1'b0;
      end

      if (capture)
        shadow <= mem_rdata;

      // Swap consumes the old prefetch first; a same-cycle request then invalidates.
      if (disp_req)
        shadow_vld <= 1'b0;
      else if (capture && !(disp_swap && !shadow_vld))
        shadow_vld <= 1'b1;
      else if (disp_swap)
        shadow_vld <= 1'b0;

      if (disp_swap && shadow_vld)
        bitmap_data <= shadow;
      else if (disp_swap && capture)
        bitmap_data <= mem_rdata;

      if (disp_swap && !shadow_vld && !capture)
        disp_underrun <= 1'b1;
      else if (clr_flags)
        disp_underrun <= 1'b0;

      if (disp_req && disp_pend && !disp_issue)
        disp_overrun <= 1'b1;
      else if (clr_flags)
        disp_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitmap_fetch_arbiter.sv
// Bench for bitmap_fetch_arbiter: RAM emulator, directed scenarios and random traffic
// compared every cycle against a transaction-level reference model.
module tb_bitmap_fetch_arbiter;

  logic        pix_clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [4:0]  disp_row = '0;
  logic        disp_swap = 1'b0;
  logic [31:0] bitmap_data;
  logic        game_req = 1'b0;
  logic        game_we = 1'b0;
  logic [4:0]  game_addr = '0;
  logic [31:0] game_wdata = '0;
  logic        game_gnt;
  logic        game_rvalid;
  logic [31:0] game_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        clr_flags = 1'b0;
  logic        disp_overrun;
  logic        disp_underrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pix_clk = ~pix_clk;

  bitmap_fetch_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .pix_clk(pix_clk), .rst(rst),
    .disp_req(disp_req), .disp_row(disp_row), .disp_swap(disp_swap),
    .bitmap_data(bitmap_data),
    .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rvalid(game_rvalid),
    .game_rdata(game_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .clr_flags(clr_flags), .disp_overrun(disp_overrun), .disp_underrun(disp_underrun)
  );

  function automatic logic [31:0] init_val(input int i);
    case (i)
      2:       return 32'h2222_0002;
      3:       return 32'h3333_0003;
      5:       return 32'hDEAD_BEEF;
      7:       return 32'h7777_0007;
      9:       return 32'h9999_0009;
      default: return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Board RAM emulator: synchronous single port, read data one cycle after issue.
  logic [31:0] ram [32];
  logic [31:0] rd_q = '0;
  bit          ram_loaded = 1'b0;
  assign mem_rdata = rd_q;

  always @(posedge pix_clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_q <= ram[mem_addr];
    end
  end

  // Reference model: RAM contents, bus occupancy countdown and display/flag bookkeeping.
  logic [31:0] ref_ram [32];
  int          m_pend  = -1;
  int          m_busy  = 0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_sh    = '0;
  bit          m_sh_ok = 1'b0;
  logic [31:0] m_bmp   = '0;
  logic [31:0] m_rdata = '0;
  bit          m_rv = 1'b0, m_ovr = 1'b0, m_und = 1'b0, m_gnt = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic req, input logic [4:0] row, input logic swap,
                      input logic greq, input logic gwe, input logic [4:0] ga,
                      input logic [31:0] gwd, input logic clr);
    bit free, d_iss, g_iss, cap, gw, old_ok, und_set, ovr_set;
    logic [4:0] exp_addr;
    @(posedge pix_clk);
    #1;
    rst = r; disp_req = req; disp_row = row; disp_swap = swap;
    game_req = greq; game_we = gwe; game_addr = ga; game_wdata = gwd; clr_flags = clr;
    @(negedge pix_clk);
    check("bitmap_data", bitmap_data, m_bmp);
    check("game_rvalid", game_rvalid, m_rv);
    check("game_rdata", game_rdata, m_rdata);
    check("disp_overrun", disp_overrun, m_ovr);
    check("disp_underrun", disp_underrun, m_und);
    free  = (m_busy == 0) && !r;
    d_iss = free && (m_pend >= 0);
    g_iss = free && (m_pend < 0) && greq;
    check("game_gnt", game_gnt, g_iss);
    check("mem_en", mem_en, d_iss || g_iss);
    check("mem_we", mem_we, g_iss && gwe);
    exp_addr = d_iss ? m_pend[4:0] : ga;
    if (d_iss || g_iss) check("mem_addr", mem_addr, exp_addr);
    if (g_iss && gwe) check("mem_wdata", mem_wdata, gwd);
    m_gnt = g_iss;
    if (r) begin
      m_pend = -1; m_busy = 0; m_sh = '0; m_sh_ok = 0; m_bmp = '0;
      m_rdata = '0; m_rv = 0; m_ovr = 0; m_und = 0;
      return;
    end
    cap = (m_busy == 1);
    gw  = (m_busy == 2);
    m_rv = gw;
    if (gw) m_rdata = m_fetch;
    ovr_set = req && (m_pend >= 0) && !d_iss;
    old_ok  = m_sh_ok;
    und_set = 0;
    if (swap) begin
      if (old_ok)   m_bmp = m_sh;
      else if (cap) m_bmp = m_fetch;
      else          und_set = 1;
    end
    if (cap) m_sh = m_fetch;
    if (req)                           m_sh_ok = 0;
    else if (cap && !(swap && !old_ok)) m_sh_ok = 1;
    else if (swap)                     m_sh_ok = 0;
    if (d_iss) m_fetch = ref_ram[m_pend[4:0]];
    if (g_iss) begin
      if (gwe) ref_ram[ga] = gwd;
      else     m_fetch = ref_ram[ga];
    end
    if (req)        m_pend = int'(row);
    else if (d_iss) m_pend = -1;
    m_busy = d_iss ? 1 : (g_iss && !gwe) ? 2 : 0;
    m_und = und_set ? 1'b1 : clr ? 1'b0 : m_und;
    m_ovr = ovr_set ? 1'b1 : clr ? 1'b0 : m_ovr;
  endtask

  task automatic idle();
    step(0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 0);
  endtask

  initial begin
    logic        g_req, g_we;
    logic [4:0]  g_addr;
    logic [31:0] g_wd;
    for (int i = 0; i < 32; i++) ref_ram[i] = init_val(i);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           $urandom, 1'($urandom_range(0, 1)));
    check("rst_bitmap", bitmap_data, 32'h0);
    check("rst_rdata", game_rdata, 32'h0);
    check("rst_mem_en", mem_en, 1'b0);
    idle();

    // Plain display fetch of row 5 then swap
    step(0, 1, 5'd5, 0, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t2_en", mem_en, 1'b1);
    check("t2_addr", mem_addr, 5'd5);
    idle(); idle();
    step(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t2_bitmap", bitmap_data, 32'hDEAD_BEEF);
    check("t2_flags", {disp_overrun, disp_underrun}, 2'b00);

    // Game read wins when display is not yet pending
    step(0, 1, 5'd11, 0, 1, 0, 5'd2, 32'h0, 0);
    check("t3_gnt", game_gnt, 1'b1);
    idle();
    check("t3_wait_en", mem_en, 1'b0);
    idle();
    check("t3_rvalid", game_rvalid, 1'b1);
    check("t3_rdata", game_rdata, 32'h2222_0002);
    check("t3_disp_addr", mem_addr, 5'd11);
    idle(); idle();
    step(0, 1, 5'd12, 0, 1, 1, 5'd4, 32'hA5A5_0004, 0);
    check("t3_wr_gnt", game_gnt, 1'b1);
    idle();
    check("t3_wr_disp_en", mem_en & ~mem_we, 1'b1);
    check("t3_wr_disp_addr", mem_addr, 5'd12);
    idle(); idle();

    // Pending display blocks a held game write to the same row
    step(0, 1, 5'd7, 0, 0, 0, 5'd0, 32'h0, 0);
    step(0, 0, 5'd0, 0, 1, 1, 5'd7, 32'h1, 0);
    check("t4_gnt_blocked", game_gnt, 1'b0);
    check("t4_disp_addr", mem_addr, 5'd7);
    step(0, 0, 5'd0, 0, 1, 1, 5'd7, 32'h1, 0);
    check("t4_gnt_wait", game_gnt, 1'b0);
    step(0, 0, 5'd0, 0, 1, 1, 5'd7, 32'h1, 0);
    check("t4_gnt_late", game_gnt, 1'b1);
    step(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t4_bitmap_old", bitmap_data, 32'h7777_0007);

    // Overrun: row 3 replaced by row 9 while the bus is busy
    step(0, 1, 5'd3, 0, 1, 0, 5'd8, 32'h0, 0);
    step(0, 1, 5'd9, 0, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t5_overrun", disp_overrun, 1'b1);
    check("t5_addr", mem_addr, 5'd9);
    idle();
    step(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t5_bitmap", bitmap_data, 32'h9999_0009);

    // Underrun and sticky flag clearing
    step(0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 1);
    idle();
    check("t6_ovr_clr", disp_overrun, 1'b0);
    step(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 0);
    idle();
    check("t6_hold", bitmap_data, 32'h9999_0009);
    check("t6_und", disp_underrun, 1'b1);
    step(0, 0, 5'd0, 0, 0, 0, 5'd0, 32'h0, 1);
    idle();
    check("t6_und_clr", disp_underrun, 1'b0);
    step(0, 0, 5'd0, 1, 0, 0, 5'd0, 32'h0, 1);
    idle();
    check("t6_set_wins", disp_underrun, 1'b1);

    // Random traffic with occasional mid-run resets; game requests held until granted
    g_req = 0; g_we = 0; g_addr = '0; g_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!g_req || m_gnt) begin
        g_req  = ($urandom_range(0, 2) != 0);
        g_we   = 1'($urandom_range(0, 1));
        g_addr = 5'($urandom_range(0, 31));
        g_wd   = $urandom;
      end
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 5) == 0),
           5'($urandom_range(0, 31)), ($urandom_range(0, 5) == 0),
           g_req, g_we, g_addr, g_wd, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
